// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage register scoreboard: counts outstanding writes per register,
// resolves RAW/structural hazards, and sequences the post-jump wrong-path kill.
module decode_hazard_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             rs_addr,
    input  logic [4:0]             rt_addr,
    input  logic                   rs_used,
    input  logic                   rt_used,
    input  logic [4:0]             dst_addr,
    input  logic                   dst_wr,
    input  logic                   jump_in,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_addr,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   bubble_ex,
    output logic                   issue_fire,
    output logic                   flush_if,
    output logic                   sb_underflow,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned ADDR_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] eff   [NUM_REGS];

    logic                   underflow_q, underflow_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_busy;
    logic rt_busy;
    logic dst_full;
    logic uf_hit;
    logic in_flush;
    logic hazard;
    logic fire;

    // Effective count: a same-cycle writeback already frees its register
    always_comb begin
        eff[0] = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (wb_valid && (wb_addr == ADDR_W'(r)) && (cnt_q[r] != '0)) begin
                eff[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                eff[r] = cnt_q[r];
            end
        end
    end

    // Per-register lookups; register 0 is never busy or full
    always_comb begin
        rs_busy  = 1'b0;
        rt_busy  = 1'b0;
        dst_full = 1'b0;
        uf_hit   = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (rs_used && (rs_addr == ADDR_W'(r)) && (eff[r] != '0)) begin
                rs_busy = 1'b1;
            end
            if (rt_used && (rt_addr == ADDR_W'(r)) && (eff[r] != '0)) begin
                rt_busy = 1'b1;
            end
            if (dst_wr && (dst_addr == ADDR_W'(r)) && (eff[r] == CNT_MAX)) begin
                dst_full = 1'b1;
            end
            if (wb_valid && (wb_addr == ADDR_W'(r)) && (cnt_q[r] == '0)) begin
                uf_hit = 1'b1;
            end
        end
    end

    // Gating with reset keeps the outputs at their idle values while reset is low
    always_comb begin
        in_flush   = (state_q == ST_FLUSH);
        hazard     = reset && id_valid && !in_flush && (rs_busy || rt_busy || dst_full);
        fire       = reset && id_valid && !hazard && !in_flush;
        stall_if   = hazard;
        stall_id   = hazard;
        bubble_ex  = !reset || hazard || in_flush || !id_valid;
        issue_fire = fire;
        flush_if   = fire && jump_in;
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = eff[r] + CNT_W'(fire && dst_wr && (dst_addr == ADDR_W'(r)));
        end
    end

    // Next-state logic; flush has priority so a jump out of STALL still kills IF
    always_comb begin
        state_d = ST_RUN;
        if (flush_if) begin
            state_d = ST_FLUSH;
        end else if (in_flush) begin
            state_d = ST_RUN;
        end else if (hazard) begin
            state_d = ST_STALL;
        end
    end

    always_comb begin
        underflow_d = underflow_q || uf_hit;
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            underflow_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            underflow_q <= underflow_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign sb_underflow = underflow_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed bench for decode_hazard_scoreboard: RAW stalls, counter saturation,
// $0 handling, jump flush, underflow flag and stall-counter saturation.
module tb_decode_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic [4:0]  dst_addr;
    logic        dst_wr;
    logic        jump_in;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        issue_fire;
    logic        flush_if;
    logic        sb_underflow;
    logic [15:0] stall_cycles;

    int checks;
    int errors;

    decode_hazard_scoreboard #(
        .NUM_REGS   (32),
        .CNT_W      (2),
        .STALL_CNT_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .dst_addr    (dst_addr),
        .dst_wr      (dst_wr),
        .jump_in     (jump_in),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .issue_fire  (issue_fire),
        .flush_if    (flush_if),
        .sb_underflow(sb_underflow),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle's ID/WB inputs; callers check outputs #2 later
    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic [4:0] dst, input logic dw, input logic j,
                         input logic wv, input logic [4:0] wa);
        id_valid = v;  rs_addr = rs;  rs_used = rsu;  rt_addr = rt;  rt_used = rtu;
        dst_addr = dst; dst_wr = dw;  jump_in = j;    wb_valid = wv; wb_addr = wa;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0);
        checks++;
        if ({stall_if, stall_id, issue_fire, flush_if, bubble_ex} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00001",
                     {stall_if, stall_id, issue_fire, flush_if, bubble_ex});
        end
        next_cycle();
        checks++;
        if (sb_underflow !== 1'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: uf=%b cyc=%0d want 0/0", sb_underflow, stall_cycles);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_raw();
        // add $3 <- $1,$2
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (issue_fire !== 1'b1 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL raw_producer: fire=%b stall=%b want 1/0", issue_fire, stall_if);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            checks++;
            if ({stall_if, stall_id, bubble_ex, issue_fire} !== 4'b1110) begin
                errors++;
                $display("FAIL raw_stall[%0d]: got %b want 1110", i,
                         {stall_if, stall_id, bubble_ex, issue_fire});
            end
            next_cycle();
        end
        drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        checks++;
        if (stall_if !== 1'b0 || issue_fire !== 1'b1) begin
            errors++;
            $display("FAIL raw_wb_issue: stall=%b fire=%b want 0/1", stall_if, issue_fire);
        end
        next_cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (stall_if !== 1'b0 || issue_fire !== 1'b1 || stall_cycles !== 16'd3) begin
            errors++;
            $display("FAIL raw_cleared: stall=%b fire=%b cyc=%0d want 0/1/3",
                     stall_if, issue_fire, stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_counter_full();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
            checks++;
            if (issue_fire !== 1'b1) begin
                errors++;
                $display("FAIL full_fill[%0d]: fire=%b want 1", i, issue_fire);
            end
            next_cycle();
        end
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (stall_if !== 1'b1 || issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: stall=%b fire=%b want 1/0", stall_if, issue_fire);
        end
        next_cycle();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5);
        checks++;
        if (stall_if !== 1'b0 || issue_fire !== 1'b1) begin
            errors++;
            $display("FAIL full_wb_issue: stall=%b fire=%b want 0/1", stall_if, issue_fire);
        end
        next_cycle();
        // Net change was zero, so the counter is still full
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (stall_if !== 1'b1) begin
            errors++;
            $display("FAIL full_still_3: stall=%b want 1", stall_if);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
            checks++;
            if (bubble_ex !== 1'b1 || issue_fire !== 1'b0) begin
                errors++;
                $display("FAIL full_drain[%0d]: bub=%b fire=%b want 1/0", i, bubble_ex, issue_fire);
            end
            next_cycle();
        end
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (issue_fire !== 1'b1 || sb_underflow !== 1'b0 || stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL full_drained: fire=%b uf=%b cyc=%0d want 1/0/5",
                     issue_fire, sb_underflow, stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_reg_zero();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0);
            checks++;
            if (stall_if !== 1'b0 || issue_fire !== 1'b1) begin
                errors++;
                $display("FAIL zero_issue[%0d]: stall=%b fire=%b want 0/1", i, stall_if, issue_fire);
            end
            next_cycle();
        end
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (sb_underflow !== 1'b0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL zero_state: uf=%b stall=%b want 0/0", sb_underflow, stall_if);
        end
        next_cycle();
    endtask

    task automatic test_jump();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0);
        checks++;
        if ({issue_fire, flush_if, bubble_ex} !== 3'b110) begin
            errors++;
            $display("FAIL jump_fire: got %b want 110", {issue_fire, flush_if, bubble_ex});
        end
        next_cycle();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0);
        checks++;
        if ({bubble_ex, issue_fire, flush_if, stall_if} !== 4'b1000) begin
            errors++;
            $display("FAIL jump_flush_cycle: got %b want 1000",
                     {bubble_ex, issue_fire, flush_if, stall_if});
        end
        next_cycle();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
        checks++;
        if (issue_fire !== 1'b1 || bubble_ex !== 1'b0) begin
            errors++;
            $display("FAIL jump_back_run: fire=%b bub=%b want 1/0", issue_fire, bubble_ex);
        end
        next_cycle();
        // Jump depending on $9 must not flush while stalled
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        checks++;
        if ({stall_if, flush_if, issue_fire} !== 3'b100) begin
            errors++;
            $display("FAIL jump_stalled: got %b want 100", {stall_if, flush_if, issue_fire});
        end
        next_cycle();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9);
        checks++;
        if ({stall_if, flush_if, issue_fire} !== 3'b011) begin
            errors++;
            $display("FAIL jump_release: got %b want 011", {stall_if, flush_if, issue_fire});
        end
        next_cycle();
        drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (bubble_ex !== 1'b1 || issue_fire !== 1'b0 || stall_cycles !== 16'd6) begin
            errors++;
            $display("FAIL jump_flush2: bub=%b fire=%b cyc=%0d want 1/0/6",
                     bubble_ex, issue_fire, stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_underflow();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
        checks++;
        if (sb_underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_pre: uf=%b want 0", sb_underflow);
        end
        next_cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        next_cycle();
        next_cycle();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (sb_underflow !== 1'b1 || issue_fire !== 1'b1 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL uf_sticky: uf=%b fire=%b stall=%b want 1/1/0",
                     sb_underflow, issue_fire, stall_if);
        end
        next_cycle();
    endtask

    task automatic test_saturation_and_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #3;
        checks++;
        if (stall_cycles !== 16'hFFFF || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL stall_saturate: cyc=%0d stall=%b want 65535/1", stall_cycles, stall_if);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({stall_if, stall_id, issue_fire, flush_if, bubble_ex} !== 5'b00001
            || sb_underflow !== 1'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: outs=%b uf=%b cyc=%0d want 00001/0/0",
                     {stall_if, stall_id, issue_fire, flush_if, bubble_ex},
                     sb_underflow, stall_cycles);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (stall_if !== 1'b0 || issue_fire !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_issue: stall=%b fire=%b want 0/1", stall_if, issue_fire);
        end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        next_cycle();
        test_reset();
        test_raw();
        test_counter_full();
        test_reg_zero();
        test_jump();
        test_underflow();
        test_saturation_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
